// File: rtl/uart_tx.sv
// UART transmitter: frames a parallel payload as one low start bit, PAYLOAD_BITS
// data bits LSB-first and STOP_BITS high stop bits, driving the line from a register.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  output logic                    uart_tx_done,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int          CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam logic [15:0] CYC_LAST       = 16'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]  BIT_LAST       = 4'(PAYLOAD_BITS - 1);
  localparam logic [1:0]  STOP_LAST      = 2'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, STOP} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cycle_q, cycle_d;
  logic [3:0]              bit_q, bit_d;
  logic [1:0]              stop_q, stop_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cycle_q <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: the line value for each bit is loaded at its leading edge.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (cycle_q == CYC_LAST);
    if (state_q != IDLE) begin
      cycle_d = bit_end ? 16'd0 : cycle_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        cycle_d = 16'd0;
        if (uart_tx_en && !busy_q) begin
          data_d  = uart_tx_data;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d   = data_q[0];
          data_d  = data_q >> 1;
          bit_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            txd_d   = 1'b1;
            bit_d   = 4'd0;
            stop_d  = 2'd0;
            state_d = STOP;
          end else begin
            bit_d  = bit_q + 4'd1;
            txd_d  = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            stop_d  = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits) driven by directed and
// randomized frames, checked against an ideal-waveform model and a mid-bit sampling receiver.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en1 = 1'b0, en2 = 1'b0;
  logic [7:0] data1 = 8'h00, data2 = 8'h00;
  logic       txd1, busy1, done1, txd2, busy2, done2;
  int         checks = 0;
  int         failures = 0;

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .resetn(resetn), .uart_txd(txd1), .uart_tx_busy(busy1),
    .uart_tx_done(done1), .uart_tx_en(en1), .uart_tx_data(data1));

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .uart_txd(txd2), .uart_tx_busy(busy2),
    .uart_tx_done(done2), .uart_tx_en(en2), .uart_tx_data(data2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] outs(input int sel);
    return (sel == 0) ? {txd1, busy1, done1} : {txd2, busy2, done2};
  endfunction

  task automatic drive(input int sel, input logic en, input logic [7:0] d);
    if (sel == 0) begin en1 = en; data1 = d; end
    else          begin en2 = en; data2 = d; end
  endtask

  task automatic set_en(input int sel, input logic en);
    if (sel == 0) en1 = en; else en2 = en;
  endtask

  task automatic set_data(input int sel, input logic [7:0] d);
    if (sel == 0) data1 = d; else data2 = d;
  endtask

  // Idle line expected for n cycles: txd high, no busy, no done.
  task automatic idle_check(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(outs(sel)), 32'b100);
      step();
    end
  endtask

  // Ideal line value at bit slot i of a frame carrying d.
  function automatic logic ideal_bit(input int i, input logic [7:0] d);
    if (i == 0) return 1'b0;
    if (i <= 8) return 1'((d >> (i - 1)) & 8'h01);
    return 1'b1;
  endfunction

  // Send one frame: accept edge, then every cycle of the frame is compared with the
  // ideal waveform; a receiver samples mid-bit and reassembles the byte.
  // keep_en holds the request high (with next_d) for back-to-back frames.
  task automatic frame(input int sel, input logic [7:0] d, input bit keep_en,
                       input logic [7:0] next_d, input int chg_k, input logic [7:0] chg_d,
                       input int req_k, input logic [7:0] req_d, input string tag);
    int         sb = (sel == 0) ? 1 : 2;
    int         fc = CPB * (9 + sb);
    int         nslots = 9 + sb;
    logic [11:0] rx = '0;
    logic [2:0] o;
    int         busy_cnt = 0;
    drive(sel, 1'b1, d);
    step();
    if (keep_en) drive(sel, 1'b1, next_d);
    else         set_en(sel, 1'b0);
    for (int k = 0; k < fc; k++) begin
      o = outs(sel);
      chk({tag, "_txd"}, 32'(o[2]), 32'(ideal_bit(k / CPB, d)));
      chk({tag, "_bd"}, 32'(o[1:0]), 32'b10);
      if (o[1]) busy_cnt++;
      if (k % CPB == CPB / 2) rx[k / CPB] = o[2];
      if (k == chg_k) set_data(sel, chg_d);
      if (k == req_k) drive(sel, 1'b1, req_d);
      else if (!keep_en) set_en(sel, 1'b0);
      step();
    end
    o = outs(sel);
    chk({tag, "_end"}, 32'(o), 32'b101);
    chk({tag, "_busycnt"}, 32'(busy_cnt), 32'(fc));
    chk({tag, "_rxstart"}, 32'(rx[0]), 32'd0);
    chk({tag, "_rxstop"}, 32'(rx[nslots-1] & rx[9]), 32'd1);
    chk({tag, "_rxbyte"}, 32'(rx[8:1]), 32'(d));
  endtask

  logic [7:0] rd, rd2, chg;
  int         rk;

  initial begin
    // 1: reset and idle
    repeat (3) step();
    chk("rst1", 32'(outs(0)), 32'b100);
    chk("rst2", 32'(outs(1)), 32'b100);
    @(negedge clk);
    resetn = 1'b1;
    step();
    idle_check(0, 200, "idle1");
    idle_check(1, 5, "idle2");

    // 2: single frame
    frame(0, 8'hA5, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, "a5");
    step();
    idle_check(0, 5, "a5_after");

    // 3: request while busy is ignored
    frame(0, 8'h3C, 1'b0, 8'h00, -1, 8'h00, 49, 8'hFF, "busyreq");
    step();
    idle_check(0, 120, "busyreq_after");

    // 4: back-to-back with request held high
    frame(0, 8'h00, 1'b1, 8'hFF, -1, 8'h00, -1, 8'h00, "b2b_0");
    frame(0, 8'hFF, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, "b2b_1");
    step();
    idle_check(0, 5, "b2b_after");

    // 5: data change mid-frame
    frame(0, 8'h81, 1'b0, 8'h00, 29, 8'h7E, -1, 8'h00, "chg81");
    step();
    idle_check(0, 3, "chg81_after");

    // 6: reset mid-frame takes effect without a clock edge
    drive(0, 1'b1, 8'hC3);
    step();
    set_en(0, 1'b0);
    repeat (35) step();
    chk("mid_busy", 32'(outs(0)), {29'd0, ideal_bit(3, 8'hC3), 2'b10});
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst", 32'(outs(0)), 32'b100);
    repeat (3) step();
    chk("mid_rst_hold", 32'(outs(0)), 32'b100);
    @(negedge clk);
    resetn = 1'b1;
    step();
    idle_check(0, 5, "post_rst");
    frame(0, 8'h55, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, "x55");
    step();
    idle_check(0, 3, "x55_after");

    // 7: two stop bits
    frame(1, 8'h0F, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, "sb2_0f");
    step();
    idle_check(1, 5, "sb2_after");

    // Randomized frames on both instances with random data changes and stray requests
    for (int n = 0; n < 8; n++) begin
      rd  = 8'($urandom);
      rd2 = 8'($urandom);
      chg = 8'($urandom);
      rk  = int'($urandom_range(1, 95));
      frame(n % 2, rd, 1'b0, 8'h00, rk, chg, int'($urandom_range(0, 98)), rd2, "rnd");
      if (n == 5) begin
        frame(n % 2, rd2, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, "rnd_b2b");
      end
      step();
      idle_check(n % 2, int'($urandom_range(1, 4)), "rnd_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
